// File: rtl/hamming_tx_serializer_if.sv
// Word handshake between the data source and the Hamming(7,4) transmit serializer.
//   in_valid  source presents in_data
//   in_ready  serializer can take a word (combinational, high while idle)
//   in_data   width-bit word; nibble i = in_data[i*4 +: 4]
// Modports: master = word source, slave = serializer.
interface hamming_tx_serializer_if #(
    parameter int unsigned width = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/hamming_tx_serializer.sv
// Transmit end of the Hamming(7,4) serial link. Accepts a width-bit word,
// splits it into width/4 nibbles, encodes each as d0,d1,d2,d3,p1,p2,p3 and
// shifts the codewords out one bit per enabled clock (nibble 0 first).
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   enable      clock enable; when low all state and outputs hold
//   bus         word handshake (slave modport: in_valid, in_ready, in_data)
//   serial_out  registered codeword bit
//   frame_out   registered, high while serial_out carries a frame bit
//   done        registered pulse in the cycle after the last frame bit
// Optional feature: define ERR_INJECT_EN to add inject / inject_pos, which
// invert codeword bit inject_pos of block 0 in a frame accepted with inject=1.
module hamming_tx_serializer #(
    parameter int unsigned width = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    hamming_tx_serializer_if.slave  bus,
`ifdef ERR_INJECT_EN
    input  logic                    inject,
    input  logic [2:0]              inject_pos,
`endif
    output logic                    serial_out,
    output logic                    frame_out,
    output logic                    done
);

    localparam int unsigned BLOCKS = width / 4;
    localparam int unsigned BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLOCKS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state,   state_nxt;
    logic [width-1:0] data_q,  data_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [BLK_W-1:0] blk_cnt, blk_nxt;
    logic             serial_nxt, frame_nxt, done_nxt;

    logic             last_bit;
    logic [2:0]       adv_bit;
    logic [BLK_W-1:0] adv_blk;
    logic [3:0]       adv_nib;
    logic             flip_first;
    logic             flip_adv;

    // Codeword bit in transmit order: data bits 0..3, then p1, p2, p3.
    function automatic logic cw_bit(input logic [3:0] nib, input logic [2:0] pos);
        logic b;
        case (pos)
            3'd0:    b = nib[0];
            3'd1:    b = nib[1];
            3'd2:    b = nib[2];
            3'd3:    b = nib[3];
            3'd4:    b = nib[0] ^ nib[2] ^ nib[3];
            3'd5:    b = nib[0] ^ nib[1] ^ nib[3];
            3'd6:    b = nib[0] ^ nib[1] ^ nib[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    assign bus.in_ready = (state == IDLE);

    // Position of the bit that follows the one currently presented.
    assign last_bit = (bit_cnt == 3'd6) && (blk_cnt == LAST_BLK);
    assign adv_bit  = (bit_cnt == 3'd6) ? 3'd0 : bit_cnt + 3'd1;
    assign adv_blk  = (bit_cnt == 3'd6) ? blk_cnt + BLK_W'(1) : blk_cnt;
    assign adv_nib  = data_q[{adv_blk, 2'b00} +: 4];

`ifdef ERR_INJECT_EN
    logic       inj_q,     inj_nxt;
    logic [2:0] inj_pos_q, inj_pos_nxt;

    // inject_pos 7 never matches a bit index, so it injects nothing.
    assign flip_first = inject && (inject_pos == 3'd0);
    assign flip_adv   = inj_q && (adv_blk == '0) && (adv_bit == inj_pos_q);
`else
    assign flip_first = 1'b0;
    assign flip_adv   = 1'b0;
`endif

    // Next-state and output logic.
    always_comb begin
        state_nxt  = state;
        data_nxt   = data_q;
        bit_nxt    = bit_cnt;
        blk_nxt    = blk_cnt;
        serial_nxt = serial_out;
        frame_nxt  = frame_out;
        done_nxt   = 1'b0;
`ifdef ERR_INJECT_EN
        inj_nxt     = inj_q;
        inj_pos_nxt = inj_pos_q;
`endif
        case (state)
            IDLE: begin
                serial_nxt = 1'b0;
                frame_nxt  = 1'b0;
                if (bus.in_valid) begin
                    state_nxt  = SEND;
                    data_nxt   = bus.in_data;
                    bit_nxt    = 3'd0;
                    blk_nxt    = '0;
                    serial_nxt = bus.in_data[0] ^ flip_first;
                    frame_nxt  = 1'b1;
`ifdef ERR_INJECT_EN
                    inj_nxt     = inject;
                    inj_pos_nxt = inject_pos;
`endif
                end
            end
            SEND: begin
                if (last_bit) begin
                    state_nxt  = IDLE;
                    serial_nxt = 1'b0;
                    frame_nxt  = 1'b0;
                    done_nxt   = 1'b1;
                end else begin
                    bit_nxt    = adv_bit;
                    blk_nxt    = adv_blk;
                    serial_nxt = cw_bit(adv_nib, adv_bit) ^ flip_adv;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; everything freezes while enable is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            data_q     <= '0;
            bit_cnt    <= 3'd0;
            blk_cnt    <= '0;
            serial_out <= 1'b0;
            frame_out  <= 1'b0;
            done       <= 1'b0;
`ifdef ERR_INJECT_EN
            inj_q      <= 1'b0;
            inj_pos_q  <= 3'd0;
`endif
        end else if (enable) begin
            state      <= state_nxt;
            data_q     <= data_nxt;
            bit_cnt    <= bit_nxt;
            blk_cnt    <= blk_nxt;
            serial_out <= serial_nxt;
            frame_out  <= frame_nxt;
            done       <= done_nxt;
`ifdef ERR_INJECT_EN
            inj_q      <= inj_nxt;
            inj_pos_q  <= inj_pos_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Scoreboard bench for hamming_tx_serializer (width=64). The driver pushes the
// expected per-cycle output tuple {frame_out, serial_out, done, in_ready} when a
// word is accepted; the monitor pops one tuple every cycle the queue is non-empty.
module tb_hamming_tx_serializer;

    localparam int unsigned W = 64;
    localparam int unsigned N = 7 * (W / 4);

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic serial_out, frame_out, done;
`ifdef ERR_INJECT_EN
    logic       inject;
    logic [2:0] inject_pos;
`endif

    hamming_tx_serializer_if #(.width(W)) bus();

    hamming_tx_serializer #(.width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
`ifdef ERR_INJECT_EN
        .inject     (inject),
        .inject_pos (inject_pos),
`endif
        .serial_out (serial_out),
        .frame_out  (frame_out),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed codewords, transmit order MSB first: d0 d1 d2 d3 p1 p2 p3.
    logic [6:0] cw_tab [16] = '{
        7'b0000000, 7'b1000111, 7'b0100011, 7'b1100100,
        7'b0010101, 7'b1010010, 7'b0110110, 7'b1110001,
        7'b0001110, 7'b1001001, 7'b0101101, 7'b1101010,
        7'b0011011, 7'b1011100, 7'b0111000, 7'b1111111
    };

    typedef logic [3:0] exp_t;   // {frame_out, serial_out, done, in_ready}
    exp_t sb [$];
    exp_t mon_item;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_item = sb.pop_front();
            check("stream{frame,serial,done,ready}",
                  64'({frame_out, serial_out, done, bus.in_ready}), 64'(mon_item));
        end
    end

    // Queue a whole frame; reps>1 when each output is expected to be held.
    task automatic push_frame(input logic [63:0] d, input int reps, input bit tail_idle,
                              input int flip_pos);
        logic [6:0] cw;
        logic [3:0] nib;
        for (int b = 0; b < W / 4; b++) begin
            nib = d[b*4 +: 4];
            cw  = cw_tab[nib];
            if (b == 0 && flip_pos >= 0 && flip_pos < 7) cw[6-flip_pos] = ~cw[6-flip_pos];
            for (int k = 0; k < 7; k++)
                for (int r = 0; r < reps; r++) sb.push_back({1'b1, cw[6-k], 1'b0, 1'b0});
        end
        for (int r = 0; r < reps; r++) sb.push_back(4'b0011);
        if (tail_idle) sb.push_back(4'b0001);
    endtask

    // Present a word and return #1 after the accepting edge.
    task automatic accept(input logic [63:0] d, input bit inj, input logic [2:0] pos,
                          input bit keep, output int at_cyc);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
`ifdef ERR_INJECT_EN
        inject     = inj;
        inject_pos = pos;
`else
        if (inj || pos != 3'd0) $display("note: inject ignored in this build");
`endif
        while (!(bus.in_ready === 1'b1 && enable === 1'b1)) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout @cyc %0d: in_ready never high", cyc);
                break;
            end
        end
        @(posedge clk);
        at_cyc = cyc;
        #1;
        if (!keep) bus.in_valid = 1'b0;
`ifdef ERR_INJECT_EN
        inject = 1'b0;
`endif
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                n_vec++;
                n_bad++;
                $display("FAIL drain_timeout: %0d items left", sb.size());
                sb.delete();
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        logic [63:0] w;
        rst          = 1'b0;
        enable       = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
`ifdef ERR_INJECT_EN
        inject     = 1'b0;
        inject_pos = 3'd0;
`endif
        repeat (3) @(negedge clk);
        check("reset_serial", 64'(serial_out), 64'd0);
        check("reset_frame",  64'(frame_out),  64'd0);
        check("reset_done",   64'(done),       64'd0);
        check("reset_ready",  64'(bus.in_ready), 64'd1);
        rst = 1'b1;
        @(negedge clk);

        // Low byte FB: 1101010 then 1111111, rest zero codewords.
        w = 64'h0000_0000_0000_00FB;
        accept(w, 1'b0, 3'd0, 1'b0, t1);
        push_frame(w, 1, 1'b1, -1);
        drain();

        // All-zero word: 112 zero bits with frame_out high.
        w = 64'h0;
        accept(w, 1'b0, 3'd0, 1'b0, t1);
        push_frame(w, 1, 1'b1, -1);
        drain();

        // Every nibble value once.
        w = 64'hFEDC_BA98_7654_3210;
        accept(w, 1'b0, 3'd0, 1'b0, t1);
        push_frame(w, 1, 1'b1, -1);
        drain();

        // Back-to-back: second word accepted in the done cycle.
        w = 64'h0123_4567_89AB_CDEF;
        accept(w, 1'b0, 3'd0, 1'b1, t1);
        push_frame(w, 1, 1'b0, -1);
        w = 64'hA5A5_5A5A_F00F_0FF0;
        accept(w, 1'b0, 3'd0, 1'b0, t2);
        push_frame(w, 1, 1'b1, -1);
        check("b2b_accept_spacing", 64'(t2 - t1), 64'(N + 1));
        drain();

        // Enable low on every other edge: each bit and the done pulse doubled.
        w = 64'h1357_9BDF_2468_ACE0;
        accept(w, 1'b0, 3'd0, 1'b0, t1);
        push_frame(w, 2, 1'b1, -1);
        for (int k = 1; k <= 2 * N + 2; k++) begin
            enable = (k % 2 == 0);
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        drain();

        // Reset while bit 30 is on the line, then a fresh frame.
        w = 64'hFFFF_FFFF_FFFF_FFFF;
        accept(w, 1'b0, 3'd0, 1'b0, t1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("bit30_serial", 64'(serial_out), 64'd1);
        check("bit30_frame",  64'(frame_out),  64'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_serial", 64'(serial_out),   64'd0);
        check("abort_frame",  64'(frame_out),    64'd0);
        check("abort_done",   64'(done),         64'd0);
        check("abort_ready",  64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        w = 64'h0000_0000_0000_00FB;
        accept(w, 1'b0, 3'd0, 1'b0, t1);
        push_frame(w, 1, 1'b1, -1);
        drain();

`ifdef ERR_INJECT_EN
        // p1 of block 0 inverted: 1101110.
        w = 64'h0000_0000_0000_000B;
        accept(w, 1'b1, 3'd4, 1'b0, t1);
        push_frame(w, 1, 1'b1, 4);
        drain();
        // d0 of block 0 inverted.
        w = 64'h0000_0000_0000_005A;
        accept(w, 1'b1, 3'd0, 1'b0, t1);
        push_frame(w, 1, 1'b1, 0);
        drain();
        // Position 7 injects nothing.
        accept(w, 1'b1, 3'd7, 1'b0, t1);
        push_frame(w, 1, 1'b1, -1);
        drain();
        // Injection does not carry into the next frame.
        accept(w, 1'b0, 3'd4, 1'b0, t1);
        push_frame(w, 1, 1'b1, -1);
        drain();
`endif

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
